imem_loader: RTL and testbench

Program loader that sits upstream of the pipelined CPU and its instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles it into 16-bit instruction words.
- Writes each word into instruction memory through its write port, then verifies an XOR checksum.
- Holds the CPU in reset during the load; on success it releases reset, raises enable and pulses start.

---
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory and boots the CPU.
// A byte stream (count, then hi/lo byte pairs, then an XOR checksum) is
// assembled into 16-bit words and written one word per write strobe. The
// CPU is held in reset until the checksum matches.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | one cycle, clears word counter and checksum
// CNT   | accept word count byte (0 means 256 words)
// HI    | accept high byte of the next word
// LO    | accept low byte, write the word on the following cycle
// CSUM  | accept checksum byte and compare with the running XOR
// REL   | release CPU reset and raise enable
// GO    | one-cycle CPU start pulse
// RUN   | program loaded, CPU running, stream ignored
// ERR   | checksum mismatch, CPU held in reset until load_req or rst
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              load_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst_n,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNT,
    S_HI,
    S_LO,
    S_CSUM,
    S_REL,
    S_GO,
    S_RUN,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] word_count;
  logic [CNT_W-1:0] wl_inc;
  logic [7:0]       csum;
  logic [7:0]       hi_byte;
  logic             xfer;

  assign xfer   = in_valid & in_ready;
  assign wl_inc = words_loaded + CNT_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; byte-consuming states advance only on a transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_CNT;
      S_CNT:  if (xfer) state_nxt = S_HI;
      S_HI:   if (xfer) state_nxt = S_LO;
      S_LO: begin
        if (xfer) begin
          state_nxt = (wl_inc == word_count) ? S_CSUM : S_HI;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_nxt = (in_data == csum) ? S_REL : S_ERR;
        end
      end
      S_REL:  state_nxt = S_GO;
      S_GO:   state_nxt = S_RUN;
      S_RUN:  if (load_req) state_nxt = S_IDLE;
      S_ERR:  if (load_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: word count, checksum accumulation and the memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count   <= '0;
      csum         <= '0;
      hi_byte      <= '0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          words_loaded <= '0;
          csum         <= '0;
        end
        S_CNT: begin
          if (xfer) begin
            word_count <= (in_data == 8'd0) ? CNT_W'(256) : CNT_W'(in_data);
            csum       <= csum ^ in_data;
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_byte <= in_data;
            csum    <= csum ^ in_data;
          end
        end
        S_LO: begin
          if (xfer) begin
            csum         <= csum ^ in_data;
            mem_we       <= 1'b1;
            mem_addr     <= words_loaded[ADDR_W-1:0];
            mem_wdata    <= DATA_W'({hi_byte, in_data});
            words_loaded <= wl_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Status and CPU control outputs, registered from the upcoming state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rst_n  <= 1'b0;
      cpu_enable <= 1'b0;
      cpu_start  <= 1'b0;
    end else begin
      in_ready   <= state_nxt inside {S_CNT, S_HI, S_LO, S_CSUM};
      busy       <= state_nxt inside {S_CNT, S_HI, S_LO, S_CSUM};
      done       <= (state_nxt == S_RUN);
      err        <= (state_nxt == S_ERR);
      cpu_rst_n  <= state_nxt inside {S_REL, S_GO, S_RUN};
      cpu_enable <= state_nxt inside {S_REL, S_GO, S_RUN};
      cpu_start  <= (state_nxt == S_GO);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of directed loads, hand-written corner
// sequences and randomized loads checked against a stream-level model.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_data = 8'h00;
  logic              load_req = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_rst_n;
  logic              cpu_enable;
  logic              cpu_start;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .load_req(load_req), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n),
    .cpu_enable(cpu_enable), .cpu_start(cpu_start), .busy(busy),
    .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:7][7:0]  b;
    int               len;
    int               mode;
    bit               ok;
    int               nw;
    logic [0:3][15:0] w;
  } vec_t;

  int         vectors = 0;
  int         miscompares = 0;
  logic [23:0] wr_q[$];
  logic [23:0] exp_q[$];
  logic [7:0]  stream_q[$];
  int         start_cnt = 0;
  logic       prev_we = 1'b0;
  logic       prev_start = 1'b0;
  vec_t       tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Record every memory write and every start pulse.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_q.push_back({mem_addr, mem_wdata});
      check("we_single_cycle", 32'(prev_we), 0);
    end
    if (cpu_start) begin
      start_cnt++;
      check("start_single_cycle", 32'(prev_start), 0);
      check("start_cpu_released", 32'(cpu_rst_n & cpu_enable), 1);
    end
    prev_we    = mem_we;
    prev_start = cpu_start;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [63:0] b, input int len, input int mode,
                              input bit ok, input int nw, input logic [63:0] w);
    vec_t v;
    v.b = b; v.len = len; v.mode = mode; v.ok = ok; v.nw = nw; v.w = w;
    return v;
  endfunction

  task automatic check_reset_values();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("rst_cpu_enable", 32'(cpu_enable), 0);
    check("rst_cpu_start", 32'(cpu_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_words_loaded", 32'(words_loaded), 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_ready && busy) && n < 10);
    check("ready_for_load", 32'({in_ready, busy}), 32'b11);
    wr_q.delete();
    start_cnt = 0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
  // plus stray load_req pulses that must be ignored mid-load.
  task automatic send_stream(input int mode);
    int idx = 0;
    int cyc = 0;
    bit ph = 1'b0;
    while (idx < stream_q.size() && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0: in_valid = 1'b1;
        1: begin in_valid = ph; ph = ~ph; end
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      load_req = (mode == 2) && ($urandom_range(0, 7) == 0);
      in_data  = in_valid ? stream_q[idx] : 8'($urandom);
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    load_req = 1'b0;
    in_data  = 8'h00;
    check("stream_sent", 32'(idx), 32'(stream_q.size()));
  endtask

  // Reference: interpret the stream directly.
  task automatic model(output bit ok, output int nw);
    int n;
    logic [7:0] x;
    n = (stream_q[0] == 8'h00) ? 256 : int'(stream_q[0]);
    x = 8'h00;
    exp_q.delete();
    for (int i = 0; i <= 2 * n; i++) x = x ^ stream_q[i];
    for (int i = 0; i < n; i++)
      exp_q.push_back({8'(i), stream_q[1 + 2 * i], stream_q[2 + 2 * i]});
    ok = (x == stream_q[2 * n + 1]);
    nw = n;
  endtask

  task automatic finish_load(input bit ok, input int nw);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done || err) && n < 30);
    check("terminal_reached", 32'(done | err), 1);
    check("done", 32'(done), 32'(ok));
    check("err", 32'(err), 32'(!ok));
    check("cpu_rst_n", 32'(cpu_rst_n), 32'(ok));
    check("cpu_enable", 32'(cpu_enable), 32'(ok));
    check("in_ready_after_load", 32'(in_ready), 0);
    check("busy_after_load", 32'(busy), 0);
    check("words_loaded", 32'(words_loaded), 32'(nw));
    check("n_writes", 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      check("write_addr_data", 32'(wr_q[i]), 32'(exp_q[i]));
    check("start_pulses", 32'(start_cnt), 32'(ok));
  endtask

  task automatic return_idle();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("abort_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("abort_cpu_enable", 32'(cpu_enable), 0);
    check("abort_done", 32'(done), 0);
    check("abort_err", 32'(err), 0);
    check("abort_idle_in_ready", 32'(in_ready), 0);
    check("abort_idle_busy", 32'(busy), 0);
    @(negedge clk);
    check("idle_to_cnt_ready", 32'(in_ready), 1);
    check("idle_clears_words", 32'(words_loaded), 0);
  endtask

  task automatic run_ignore();
    logic [ADDR_W:0] wl;
    wl = words_loaded;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      check("run_no_we", 32'(mem_we), 0);
      check("run_done", 32'(done), 1);
      check("run_in_ready", 32'(in_ready), 0);
      check("run_words", 32'(words_loaded), 32'(wl));
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("run_mem_we", 32'(mem_we), 0);
    check("run_start_quiet", 32'(start_cnt), 1);
  endtask

  initial begin
    bit ok;
    int nw;
    int n;
    int mode;
    logic [7:0] x;
    logic [7:0] v;

    tbl[0] = mk({8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 16'h0}, 6, 0, 1'b1, 2,
                {16'h1234, 16'hABCD, 32'h0});
    tbl[1] = mk({8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43, 16'h0}, 6, 0, 1'b0, 2,
                {16'h1234, 16'hABCD, 32'h0});
    tbl[2] = mk({8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 16'h0}, 6, 1, 1'b1, 2,
                {16'h1234, 16'hABCD, 32'h0});
    tbl[3] = mk({8'h01, 8'h00, 8'hFF, 8'hFE, 32'h0}, 4, 0, 1'b1, 1,
                {16'h00FF, 48'h0});
    tbl[4] = mk({8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h03}, 8, 2, 1'b1, 3,
                {16'h0001, 16'h0002, 16'h0003, 16'h0});
    tbl[5] = mk({8'h01, 8'h55, 8'hAA, 8'h00, 32'h0}, 4, 1, 1'b0, 1,
                {16'h55AA, 48'h0});

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    // Directed table.
    for (int t = 0; t < 6; t++) begin
      wait_ready();
      stream_q.delete();
      for (int i = 0; i < tbl[t].len; i++) stream_q.push_back(tbl[t].b[i]);
      exp_q.delete();
      for (int i = 0; i < tbl[t].nw; i++) exp_q.push_back({8'(i), tbl[t].w[i]});
      send_stream(tbl[t].mode);
      finish_load(tbl[t].ok, tbl[t].nw);
      if (t == 0) run_ignore();
      return_idle();
    end

    // Count byte 00: 256 words, final write at address 255.
    wait_ready();
    stream_q.delete();
    stream_q.push_back(8'h00);
    x = 8'h00;
    for (int i = 0; i < 256; i++) begin
      stream_q.push_back(8'(i));
      stream_q.push_back(8'(i));
      x = x ^ 8'(i) ^ 8'(i);
    end
    stream_q.push_back(x);
    model(ok, nw);
    check("model_256_ok", 32'(ok), 1);
    send_stream(0);
    finish_load(1'b1, 256);
    return_idle();

    // Reset while waiting for the high byte of word 1.
    wait_ready();
    stream_q.delete();
    stream_q.push_back(8'h02);
    stream_q.push_back(8'h12);
    stream_q.push_back(8'h34);
    send_stream(0);
    check("mid_load_we", 32'(mem_we), 1);
    check("mid_load_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    wait_ready();
    stream_q.delete();
    stream_q.push_back(8'h01);
    stream_q.push_back(8'h00);
    stream_q.push_back(8'hFF);
    stream_q.push_back(8'hFE);
    model(ok, nw);
    send_stream(0);
    finish_load(ok, nw);
    check("post_rst_w0", 32'(wr_q.size() > 0 ? wr_q[0] : 24'hFFFFFF), 32'h0000FF);
    return_idle();

    // Randomized loads.
    for (int r = 0; r < 14; r++) begin
      wait_ready();
      n = $urandom_range(1, 12);
      stream_q.delete();
      stream_q.push_back(8'(n));
      x = 8'(n);
      for (int i = 0; i < 2 * n; i++) begin
        v = 8'($urandom);
        stream_q.push_back(v);
        x = x ^ v;
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
      stream_q.push_back(x);
      model(ok, nw);
      mode = $urandom_range(0, 2);
      send_stream(mode);
      finish_load(ok, nw);
      if (ok && r < 3) run_ignore();
      return_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
